// File: rtl/ripple_carry_adder_reg_pkg.sv
// Shared constants for the registered ripple-carry adder.
package ripple_carry_adder_reg_pkg;

  // Operand width used when an instance does not override WIDTH.
  localparam int RCA_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/ripple_carry_adder_reg_full_adder.sv
// Single-bit full adder: the repeated cell of the ripple chain.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  // The carry is propagated when the inputs differ and generated when both are set.
  always_comb begin
    s  = x ^ y ^ ci;
    co = (x & y) | (ci & (x ^ y));
  end

endmodule

// File: rtl/ripple_carry_adder_reg.sv
// Registered WIDTH-bit ripple-carry adder with one cycle of latency.
// The carry ripples through WIDTH full_adder cells with no lookahead, so the
// longest path runs from bit 0 (or c) through every stage into the carry register.
module ripple_carry_adder_reg
  import ripple_carry_adder_reg_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  // chain[i] is the carry into stage i; chain[WIDTH] is the final carry-out.
  logic [WIDTH:0]   chain;
  logic [WIDTH-1:0] chain_sum;

  assign chain[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .x  (a[i]),
      .y  (b[i]),
      .ci (chain[i]),
      .s  (chain_sum[i]),
      .co (chain[i+1])
    );
  end

  // Capture the chain result on valid input; otherwise hold the data and drop valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= chain_sum;
        carry <= chain[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder_reg.sv
// Self-checking bench for ripple_carry_adder_reg: 4-bit and 8-bit instances,
// scoreboard queues filled by the stimulus and drained by per-instance monitors.
module tb_ripple_carry_adder_reg;

  logic       clk;
  logic       rst;

  logic [3:0] a, b;
  logic       c, in_valid;
  logic [3:0] sum;
  logic       carry, out_valid;

  logic [7:0] a8, b8;
  logic       c8, in_valid8;
  logic [7:0] sum8;
  logic       carry8, out_valid8;

  int checks;
  int errors;

  logic [4:0] exp_q[$];
  logic [8:0] exp_q8[$];

  ripple_carry_adder_reg #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .c         (c),
    .in_valid  (in_valid),
    .sum       (sum),
    .carry     (carry),
    .out_valid (out_valid)
  );

  ripple_carry_adder_reg #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .a         (a8),
    .b         (b8),
    .c         (c8),
    .in_valid  (in_valid8),
    .sum       (sum8),
    .carry     (carry8),
    .out_valid (out_valid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the expected one and tally the result.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: exact integer addition, split into low bits and the carry.
  function automatic logic [4:0] model4(input int x, input int y, input int ci);
    int total;
    total = x + y + ci;
    return {total >= 16 ? 1'b1 : 1'b0, 4'(total % 16)};
  endfunction

  function automatic logic [8:0] model8(input int x, input int y, input int ci);
    int total;
    total = x + y + ci;
    return {total >= 256 ? 1'b1 : 1'b0, 8'(total % 256)};
  endfunction

  // Drive one cycle of 4-bit stimulus; valid inputs push their expected result.
  task automatic applyStimulus(input int x, input int y, input int ci, input logic v);
    a        = 4'(x);
    b        = 4'(y);
    c        = ci[0];
    in_valid = v;
    if (v) exp_q.push_back(model4(x, y, ci));
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus8(input int x, input int y, input int ci, input logic v);
    a8        = 8'(x);
    b8        = 8'(y);
    c8        = ci[0];
    in_valid8 = v;
    if (v) exp_q8.push_back(model8(x, y, ci));
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 4-bit instance: every presented result must match the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_out_valid4", 32'(out_valid), 32'd0);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        checkOutput("sum4", 32'(sum), 32'(e[3:0]));
        checkOutput("carry4", 32'(carry), 32'(e[4]));
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (!rst && out_valid8) begin
      if (exp_q8.size() == 0) begin
        checkOutput("spurious_out_valid8", 32'(out_valid8), 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q8.pop_front();
        checkOutput("sum8", 32'(sum8), 32'(e[7:0]));
        checkOutput("carry8", 32'(carry8), 32'(e[8]));
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    a = '0; b = '0; c = 1'b0; in_valid = 1'b0;
    a8 = '0; b8 = '0; c8 = 1'b0; in_valid8 = 1'b0;

    // Reset state while held, with valid input present.
    in_valid = 1'b1; a = 4'd7; b = 4'd7;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_sum", 32'(sum), 32'd0);
    checkOutput("reset_carry", 32'(carry), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_valid8", 32'(out_valid8), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Exhaustive sweeps with c=0 then c=1.
    for (int ci = 0; ci < 2; ci++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          applyStimulus(x, y, ci, 1'b1);
    applyStimulus(0, 0, 0, 1'b0);

    // Full-chain propagation and named boundaries.
    applyStimulus(15, 0, 1, 1'b1);
    applyStimulus(15, 15, 1, 1'b1);
    applyStimulus(0, 0, 0, 1'b1);
    applyStimulus(9, 7, 0, 1'b1);
    applyStimulus(0, 0, 0, 1'b0);

    // Hold: one valid result, then three idle cycles with data held.
    applyStimulus(5, 6, 0, 1'b1);
    checkOutput("hold_valid_first", 32'(out_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 1, 1'b0);
      checkOutput("hold_sum", 32'(sum), 32'd11);
      checkOutput("hold_carry", 32'(carry), 32'd0);
      checkOutput("hold_out_valid", 32'(out_valid), 32'd0);
    end

    // Randomised traffic with random gaps.
    for (int k = 0; k < 200; k++)
      applyStimulus($urandom_range(15), $urandom_range(15), $urandom_range(1), 1'($urandom_range(1)));

    // Mid-stream reset: a result is on the outputs when rst rises without a clock edge.
    applyStimulus(14, 13, 1, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_sum", 32'(sum), 32'd0);
    checkOutput("async_reset_carry", 32'(carry), 32'd0);
    checkOutput("async_reset_out_valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    a = 4'd15; b = 4'd15; c = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_held_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    applyStimulus(3, 4, 0, 1'b1);
    checkOutput("post_reset_sum", 32'(sum), 32'd7);
    applyStimulus(0, 0, 0, 1'b0);

    // 8-bit instance: overflow boundary plus random traffic.
    applyStimulus8(255, 1, 0, 1'b1);
    applyStimulus8(255, 255, 1, 1'b1);
    applyStimulus8(0, 0, 0, 1'b1);
    for (int k = 0; k < 60; k++)
      applyStimulus8($urandom_range(255), $urandom_range(255), $urandom_range(1), 1'($urandom_range(1)));
    applyStimulus8(0, 0, 0, 1'b0);

    // Let monitors drain, then confirm every expected result was presented.
    @(posedge clk);
    #1;
    checkOutput("queue4_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("queue8_drained", 32'(exp_q8.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
